fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of asyncfifo among NUM_REQ requesters.

---
 rtl/fifo_write_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing the asyncfifo write port in the write_clk domain.
// Define ARB_STALL_TIMEOUT_EN to force release of an owner stalled on mem_full for STALL_LIMIT cycles.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                          write_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          mem_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy,
    output logic                          stall_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, winner;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW:0]     cand;
    logic            found, in_burst, own_req, accept, rel, timeout;

    assign in_burst = state_q == BURST;
    assign own_req  = req[owner_q];
    assign accept   = in_burst & own_req & ~mem_full;
    assign busy     = in_burst;
    assign rel      = in_burst & (~own_req | (accept & (burst_cnt_q == BW'(MAX_BURST - 1))) | timeout);

    // Scan starts just after the last owner, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

`ifdef ARB_STALL_TIMEOUT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall, stall_err_q;

    assign stall       = in_burst & own_req & mem_full;
    assign timeout     = stall && (stall_cnt_q == SW'(STALL_LIMIT - 1));
    assign stall_cnt_d = (stall && !timeout) ? stall_cnt_q + 1'b1 : '0;
    assign stall_err   = stall_err_q;

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign stall_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        write_en    = accept;
        grant       = accept ? NUM_REQ'(1) << owner_q : '0;
        data_in     = accept ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (!in_burst) begin
            if (found) begin
                state_d     = BURST;
                owner_d     = winner;
                burst_cnt_d = '0;
            end
        end else if (rel) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q;
        end else if (accept) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed bench; expected FIFO words are queued when driven and popped on each write.
module tb_fifo_write_arbiter;
    logic        clk = 1'b0, reset = 1'b0, mem_full = 1'b0;
    logic [3:0]  req = '0, grant;
    logic [31:0] req_data = '0;
    logic        write_en, busy, stall_err;
    logic [7:0]  data_in;
    logic [7:0]  sl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  sb [$];
    int          total = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter dut (
        .write_clk(clk), .reset(reset), .req(req), .req_data(req_data), .mem_full(mem_full),
        .grant(grant), .write_en(write_en), .data_in(data_in), .busy(busy), .stall_err(stall_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rv, input logic [3:0] r, input logic f,
                       input logic [3:0] g, input logic b, input logic e);
        @(negedge clk);
        reset    = rv;
        req      = r;
        mem_full = f;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = sl[i];
        #1;
        chk("grant", 8'(grant), 8'(g));
        chk("write_en", 8'(write_en), 8'(|g));
        chk("busy", 8'(busy), 8'(b));
        chk("stall_err", 8'(stall_err), 8'(e));
        if (write_en === 1'b1) begin
            total++;
            assert (sb.size() > 0) passed++;
            else begin
                fails++;
                $error("FAIL sb_underflow observed=write expected=no_write");
            end
            if (sb.size() > 0) chk("data_in", data_in, sb.pop_front());
        end else begin
            chk("data_idle", data_in, 8'h00);
        end
    endtask

    task automatic wr(input logic [3:0] r, input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) sb.push_back(sl[i]);
        cyc(1'b1, r, 1'b0, g, 1'b1, 1'b0);
    endtask

    initial begin
        cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
            repeat (4) wr(4'b1111, 4'(1 << r));
        end
        cyc(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        wr(4'b0100, 4'b0100);
        cyc(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
        wr(4'b1111, 4'b0001);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        sl[1] = 8'hA1;
        cyc(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        wr(4'b0010, 4'b0010);
        sl[1] = 8'hA2;
        wr(4'b0010, 4'b0010);
        cyc(1'b1, 4'b1101, 1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, 4'b1101, 1'b0, 4'b0000, 1'b0, 1'b0);
        wr(4'b1101, 4'b0100);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        wr(4'b0001, 4'b0001);
        repeat (5) cyc(1'b1, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0);
        repeat (3) wr(4'b0001, 4'b0001);
        cyc(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
`ifdef ARB_STALL_TIMEOUT_EN
        repeat (16) cyc(1'b1, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b1);
        wr(4'b1001, 4'b0001);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
`else
        repeat (20) cyc(1'b1, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0);
        wr(4'b1000, 4'b1000);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
`endif
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("sb_drain", 8'(sb.size()), 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
